// File: rtl/led_fader_pkg.sv
// Shared types and elaboration helpers for the LED fader.
package led_fader_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  // Clock cycles per duty step so that a full 0..MAXD ramp lasts ramp_ms.
  function automatic longint calc_step_cyc(input longint freq, input longint ramp_ms,
                                           input int pwm_bits);
    longint maxd;
    longint cyc;
    maxd = (longint'(1) << pwm_bits) - longint'(1);
    cyc  = ((freq / longint'(1000)) * ramp_ms) / maxd;
    if (cyc < longint'(1)) begin
      return longint'(1);
    end else begin
      return cyc;
    end
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and registered LED comparator.
// Optional gamma stage enabled by LED_FADER_GAMMA_EN.
module led_pwm
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                led_o
);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] w_duty_eff;
  logic                r_led;

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_sq;
  logic [PWM_BITS-1:0]   r_gamma;

  assign w_sq = duty_i * duty_i;

  // Squared duty gives a perceptually linear fade; one pipeline stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gamma <= '0;
    end else begin
      r_gamma <= w_sq[2*PWM_BITS-1:PWM_BITS];
    end
  end

  assign w_duty_eff = r_gamma;
`else
  assign w_duty_eff = duty_i;
`endif

  // PWM counter wraps naturally at MAXD; output registered against glitches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      r_led <= (r_cnt < w_duty_eff);
    end
  end

  assign led_o = r_led;

endmodule

// File: rtl/led_fader.sv
// PWM fade-in/fade-out of the blink level: synchroniser, step prescaler, duty ramp FSM.
// Optional gamma correction in led_pwm when LED_FADER_GAMMA_EN is defined.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int FREQ     = 50_000_000,
  parameter int RAMP_MS  = 250,
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                level_i,
  input  logic                enable_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                busy_o
);

  localparam longint STEP_CYC = calc_step_cyc(longint'(FREQ), longint'(RAMP_MS), PWM_BITS);
  localparam int     PRE_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYC - 1);
  localparam logic [PWM_BITS-1:0] MAXD     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);

  if (FREQ == 0) begin : g_chk_freq
    $fatal(1, "led_fader: FREQ must be nonzero");
  end
  if (RAMP_MS < 1) begin : g_chk_ramp
    $fatal(1, "led_fader: RAMP_MS must be >= 1");
  end
  if (PWM_BITS < 2 || PWM_BITS > 12) begin : g_chk_bits
    $fatal(1, "led_fader: PWM_BITS must be 2..12");
  end

  logic                r_sync1;
  logic                r_lvl;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic [PRE_W-1:0]    r_pre;
  logic [PRE_W-1:0]    w_pre_nxt;
  logic                r_busy;
  logic                w_step;

  assign w_step = (r_pre == PRE_LAST);

  // Two-flop synchroniser for the asynchronous blink level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_lvl   <= 1'b0;
    end else begin
      r_sync1 <= level_i;
      r_lvl   <= r_sync1;
    end
  end

  // State, duty, prescaler and busy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= OFF;
      r_duty  <= '0;
      r_pre   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_pre   <= w_pre_nxt;
      r_busy  <= (w_state_nxt == RISE) || (w_state_nxt == FALL);
    end
  end

  // Prescaler restarts on any step or state change; it only advances while ramping.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_pre_nxt   = '0;
    if (!enable_i) begin
      w_state_nxt = OFF;
      w_duty_nxt  = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_duty_nxt = '0;
          if (r_lvl) begin
            w_state_nxt = RISE;
          end else begin
            w_state_nxt = OFF;
          end
        end
        RISE: begin
          if (!r_lvl) begin
            w_state_nxt = FALL;
          end else if (w_step) begin
            if (r_duty == MAXD) begin
              w_duty_nxt = MAXD;
            end else begin
              w_duty_nxt = r_duty + ONE;
            end
            if (r_duty >= (MAXD - ONE)) begin
              w_state_nxt = ON;
            end else begin
              w_state_nxt = RISE;
            end
          end else begin
            w_pre_nxt = r_pre + PRE_W'(1);
          end
        end
        ON: begin
          w_duty_nxt = MAXD;
          if (!r_lvl) begin
            w_state_nxt = FALL;
          end else begin
            w_state_nxt = ON;
          end
        end
        FALL: begin
          if (r_lvl) begin
            w_state_nxt = RISE;
          end else if (w_step) begin
            if (r_duty == '0) begin
              w_duty_nxt = '0;
            end else begin
              w_duty_nxt = r_duty - ONE;
            end
            if (r_duty <= ONE) begin
              w_state_nxt = OFF;
            end else begin
              w_state_nxt = FALL;
            end
          end else begin
            w_pre_nxt = r_pre + PRE_W'(1);
          end
        end
        default: begin
          w_state_nxt = OFF;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  led_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .duty_i(r_duty),
    .led_o (led_o)
  );

  assign duty_o = r_duty;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_led_fader.sv
// Directed self-checking bench for led_fader (FREQ=1MHz, RAMP_MS=1, PWM_BITS=4 -> STEP_CYC=66).
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic       level;
  logic       enable;
  logic       led;
  logic [3:0] duty;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef LED_FADER_GAMMA_EN
  localparam int ON_HIGHS = 14;
  localparam int LED_LAT  = 3;
`else
  localparam int ON_HIGHS = 15;
  localparam int LED_LAT  = 2;
`endif

  led_fader #(
    .FREQ    (1_000_000),
    .RAMP_MS (1),
    .PWM_BITS(4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .level_i (level),
    .enable_i(enable),
    .led_o   (led),
    .duty_o  (duty),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_duty(input logic [3:0] tgt, input int budget, output int waited);
    waited = 0;
    while (duty !== tgt && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic wait_busy(input int budget, output int waited);
    waited = 0;
    while (busy !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  int t_rise;

  task automatic test_reset();
    int n;
    int w;
    rst = 1'b1; level = 1'b1; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 1'b0 || duty !== 4'd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: led=%b duty=%0d busy=%b, expected 0/0/0", led, duty, busy);
      end
    end
    rst = 1'b0;
    wait_busy(8, n);
    t_rise = cyc;
    checks++;
    if (busy !== 1'b1 || n > 4) begin
      failures++;
      $display("FAIL reset_busy_rise: busy=%b after %0d cycles, expected 1 within 4", busy, n);
    end
    checks++;
    if (duty !== 4'd0) begin
      failures++;
      $display("FAIL reset_rise_start: duty=%0d, expected 0", duty);
    end
    wait_duty(4'd1, 80, w);
    checks++;
    if (duty !== 4'd1 || w < 65 || w > 67) begin
      failures++;
      $display("FAIL first_step: duty=%0d after %0d cycles, expected 1 after 66", duty, w);
    end
  endtask

  task automatic test_full_rise();
    int w;
    int highs;
    wait_duty(4'd15, 1000, w);
    checks++;
    if (duty !== 4'd15 || (cyc - t_rise) < 987 || (cyc - t_rise) > 993) begin
      failures++;
      $display("FAIL full_rise_time: duty=%0d after %0d cycles, expected 15 after 990", duty, cyc - t_rise);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL full_rise_busy: busy=%b, expected 0 in ON", busy);
    end
    repeat (3) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led === 1'b1) highs++;
    end
    checks++;
    if (highs !== ON_HIGHS) begin
      failures++;
      $display("FAIL on_pwm_highs: led high %0d of 16, expected %0d", highs, ON_HIGHS);
    end
  endtask

  task automatic test_enable_override();
    int bad;
    @(negedge clk);
    enable = 1'b0;
    repeat (LED_LAT) @(negedge clk);
    checks++;
    if (duty !== 4'd0 || led !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL enable_off: duty=%0d led=%b busy=%b, expected 0/0/0", duty, led, busy);
    end
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) level = ~level;
      @(negedge clk);
      if (duty !== 4'd0 || led !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL enable_ignore_level: %0d nonzero samples, expected 0", bad);
    end
    level = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (duty !== 4'd0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL enable_resume_dark: %0d nonzero samples, expected 0", bad);
    end
  endtask

  task automatic test_reversal();
    int w;
    int n;
    int mx;
    level = 1'b1;
    wait_duty(4'd7, 600, w);
    checks++;
    if (duty !== 4'd7) begin
      failures++;
      $display("FAIL reversal_reach7: duty=%0d, expected 7", duty);
    end
    level = 1'b0;
    mx = int'(duty);
    n = 0;
    while (duty !== 4'd0 && n < 531) begin
      @(negedge clk);
      n++;
      if (int'(duty) > mx) mx = int'(duty);
    end
    checks++;
    if (mx > 8) begin
      failures++;
      $display("FAIL reversal_peak: max duty=%0d, expected <= 8", mx);
    end
    checks++;
    if (duty !== 4'd0) begin
      failures++;
      $display("FAIL reversal_to_zero: duty=%0d after %0d cycles, expected 0 within 531", duty, n);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reversal_busy: busy=%b, expected 0 at OFF", busy);
    end
  endtask

  task automatic test_async_reset();
    int w;
    level = 1'b1;
    wait_duty(4'd10, 800, w);
    level = 1'b0;
    wait_duty(4'd9, 200, w);
    checks++;
    if (duty !== 4'd9 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fall_at_9: duty=%0d busy=%b, expected 9/1", duty, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (duty !== 4'd0 || led !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: duty=%0d led=%b busy=%b, expected 0/0/0", duty, led, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    level = 1'b1;
    wait_busy(8, w);
    checks++;
    if (busy !== 1'b1 || duty !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_rise: busy=%b duty=%0d, expected 1/0", busy, duty);
    end
    wait_duty(4'd1, 80, w);
    checks++;
    if (duty !== 4'd1 || w < 65 || w > 67) begin
      failures++;
      $display("FAIL post_reset_step: duty=%0d after %0d cycles, expected 1 after 66", duty, w);
    end
  endtask

  initial begin
    rst = 1'b1;
    level = 1'b0;
    enable = 1'b1;
    test_reset();
    test_full_rise();
    test_enable_override();
    test_reversal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream consumer of the blinker's LED level; turns the hard on/off square wave into a PWM-driven fade-in/fade-out on the physical LED pin.
- Sits between the blink stage and the top-level LED output.
- Parameterised by the same clock frequency as the blink stage, so ramp timing is absolute.
- Contains a step prescaler, a duty ramp state machine and a free-running PWM comparator.

Parameters:
- FREQ, 50_000_000, clock frequency in Hz; 0 triggers an elaboration-time $fatal.
- RAMP_MS, 250, duration of a full 0-to-max (or max-to-0) ramp, in milliseconds; must be >= 1.
- PWM_BITS, 8, width of the duty and PWM counters; legal range 2..12.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- level_i  in  1  LED level from the blink stage; asynchronous to the fader, synchronised internally.
- enable_i  in  1  fader enable; 0 forces the LED dark.
- led_o  out  1  PWM-modulated LED drive.
- duty_o  out  PWM_BITS  current duty value.
- busy_o  out  1  high while in RISE or FALL.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: led_o=0, duty_o=0, busy_o=0, state=OFF, all counters 0, synchroniser flops 0.
- Constants:
  - MAXD = 2^PWM_BITS-1.
  - STEP_CYC = max(1, (FREQ/1000)*RAMP_MS/MAXD), computed in 64-bit at elaboration.
- Synchroniser: level_i passes through two flops; the second flop output is lvl. lvl therefore lags level_i by 2 cycles.
- Step prescaler:
  - Counts 0..STEP_CYC-1 and pulses step for one cycle at wrap.
  - Runs only in RISE/FALL; cleared to 0 on every state entry.
- FSM states and transitions:
  - OFF (duty=0): lvl=1 and enable_i -> RISE.
  - RISE: on each step, duty+1. duty reaching MAXD -> ON. lvl=0 -> FALL immediately, keeping the current duty.
  - ON (duty=MAXD): lvl=0 -> FALL.
  - FALL: on each step, duty-1. duty reaching 0 -> OFF. lvl=1 -> RISE immediately, keeping the current duty.
- Duty arithmetic: duty saturates at 0 and MAXD; it never wraps.
- enable_i=0:
  - Takes priority in any state: next cycle state=OFF, duty=0, prescaler cleared.
  - While enable_i stays 0, level changes are ignored.
- PWM:
  - pwm_cnt is free-running PWM_BITS and wraps MAXD->0.
  - led_o is registered: led_o <= (pwm_cnt < duty_eff).
  - Boundaries: duty_eff=0 gives a constant 0; duty_eff=MAXD gives led_o low 1 cycle per PWM period (accepted).
- duty_o reflects the duty register with 0 extra latency; busy_o is registered from the state.
- Reset asserted mid-ramp: all state returns to the reset values asynchronously. After deassertion, a lvl=1 begins a fresh RISE from 0.

Optional Feature:
- Macro: LED_FADER_GAMMA_EN.
- Defined: duty_eff = (duty*duty) >> PWM_BITS, computed in a registered pipeline stage. This adds 1 cycle of latency duty->led_o and gives a perceptually linear fade.
- Not defined: duty_eff = duty, and no extra stage.
- duty_o is the unmodified duty in both builds.

Decomposition:
- Package led_fader_pkg holds:
  - state typedef enum {OFF, RISE, ON, FALL}, 2 bits;
  - function calc_step_cyc(FREQ, RAMP_MS, PWM_BITS).
- One sub-module, led_pwm: pwm_cnt, the optional gamma stage and the led_o comparator. Ports: clk_i, rst_i, duty_i, led_o.

Test Plan:
Common configuration for all scenarios: FREQ=1_000_000, RAMP_MS=1, PWM_BITS=4, giving MAXD=15 and STEP_CYC=66.
- Reset: hold rst_i 5 cycles with level_i=1 -> led_o=0, duty_o=0, busy_o=0 throughout; release -> busy_o=1 by cycle 4, duty_o=1 at step 1.
- Full rise: level_i=1 held -> duty_o reaches 15 after 15*66=990 cycles (±3), busy_o falls, state ON; over 16 cycles led_o is high 15 times.
- Mid-ramp reversal: level_i=1, then at duty_o=7 drive level_i=0 -> duty_o never exceeds 8 and decrements to 0 within 8*66+3 cycles; busy_o=0 at OFF.
- Enable override: in ON, drop enable_i -> duty_o=0 and led_o=0 within 2 cycles; toggle level_i while disabled -> no change.
- Async reset in FALL at duty 9: assert rst_i between clock edges -> outputs 0 before the next edge.
- Gamma build (LED_FADER_GAMMA_EN): duty=15 -> duty_eff=14; duty=8 -> 4 (led_o high 4 of 16 cycles); duty=3 -> 0 (led_o constantly 0).
